// File: rtl/norm_shifter.sv
// Left-normalizing shifter: shifts a mantissa up by its leading-zero count, clamped by the exponent. Latency 2 cycles.
// Backpressure: a single enable stalls both stages whenever stage 2 holds an unconsumed beat; ready_o mirrors that enable.
module norm_shifter #(
   parameter  int DATA_WIDTH = 24,
   parameter  int EXP_WIDTH  = 8,
   localparam int LZC_WIDTH  = $clog2(DATA_WIDTH + 1)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  valid_i,
   output logic                  ready_o,
   input  logic [DATA_WIDTH-1:0] a_i,
   input  logic [EXP_WIDTH-1:0]  exp_i,
   output logic                  valid_o,
   input  logic                  ready_i,
   output logic [DATA_WIDTH-1:0] c_o,
   output logic [EXP_WIDTH-1:0]  exp_o,
   output logic [LZC_WIDTH-1:0]  lzc_o,
   output logic                  zero_o,
   output logic                  denorm_o
);

   localparam int CMP_WIDTH = (EXP_WIDTH > LZC_WIDTH) ? EXP_WIDTH : LZC_WIDTH;

   typedef struct packed {
      logic [DATA_WIDTH-1:0] a;
      logic [EXP_WIDTH-1:0]  e;
      logic [LZC_WIDTH-1:0]  lzc;
   } s1_t;

   typedef struct packed {
      logic [DATA_WIDTH-1:0] c;
      logic [EXP_WIDTH-1:0]  e;
      logic [LZC_WIDTH-1:0]  lzc;
      logic                  zero;
      logic                  denorm;
   } s2_t;

   logic                 en;
   logic                 s1_vld;
   logic                 s2_vld;
   s1_t                  s1_q;
   s1_t                  s1_d;
   s2_t                  s2_q;
   s2_t                  s2_d;
   logic [LZC_WIDTH-1:0] lzc_d;
   logic [CMP_WIDTH-1:0] lzc_ext;
   logic [CMP_WIDTH-1:0] exp_ext;
   logic [CMP_WIDTH-1:0] sh;
   logic                 limited;
   logic                 is_zero;

   assign en      = !s2_vld || ready_i;
   assign ready_o = en;

   // Highest set bit wins: scanning upward, the last hit overwrites earlier ones.
   always_comb begin
      lzc_d = LZC_WIDTH'(DATA_WIDTH);
      for (int i = 0; i < DATA_WIDTH; i++) begin
         if (a_i[i]) begin
            lzc_d = LZC_WIDTH'(DATA_WIDTH - 1 - i);
         end
      end
   end

   always_comb begin
      s1_d     = '0;
      s1_d.a   = a_i;
      s1_d.e   = exp_i;
      s1_d.lzc = lzc_d;
   end

   // Shift is capped at the exponent so exp_o never wraps below zero.
   always_comb begin
      lzc_ext   = CMP_WIDTH'(s1_q.lzc);
      exp_ext   = CMP_WIDTH'(s1_q.e);
      limited   = lzc_ext > exp_ext;
      sh        = limited ? exp_ext : lzc_ext;
      is_zero   = (s1_q.a == '0);
      s2_d      = '0;
      s2_d.c    = s1_q.a << sh;
      s2_d.e    = is_zero ? '0 : (s1_q.e - EXP_WIDTH'(sh));
      s2_d.lzc  = s1_q.lzc;
      s2_d.zero = is_zero;
      s2_d.denorm = limited && !is_zero;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_vld <= 1'b0;
         s2_vld <= 1'b0;
         s1_q   <= '0;
         s2_q   <= '0;
      end else if (en) begin
         s1_vld <= valid_i;
         s1_q   <= s1_d;
         s2_vld <= s1_vld;
         s2_q   <= s2_d;
      end
   end

   assign valid_o  = s2_vld;
   assign c_o      = s2_q.c;
   assign exp_o    = s2_q.e;
   assign lzc_o    = s2_q.lzc;
   assign zero_o   = s2_q.zero;
   assign denorm_o = s2_q.denorm;

`ifndef SYNTHESIS
   // A presented beat must not change or vanish until it is taken.
   a_hold_stable : assert property (@(posedge clk) disable iff (!rst_n)
      (valid_o && !ready_i) |=> (valid_o && $stable(s2_q)));
`endif

endmodule

// File: tb/tb_norm_shifter.sv
// Randomized scoreboard bench for norm_shifter, with directed corner cases and a mid-stream reset.
module tb_norm_shifter;

   localparam int DW = 24;
   localparam int EW = 8;
   localparam int LW = 5;

   typedef struct packed {
      logic [DW-1:0] c;
      logic [EW-1:0] e;
      logic [LW-1:0] lzc;
      logic          zero;
      logic          denorm;
   } exp_t;

   logic          clk;
   logic          rst_n;
   logic          valid_i;
   logic          ready_o;
   logic [DW-1:0] a_i;
   logic [EW-1:0] exp_i;
   logic          valid_o;
   logic          ready_i;
   logic [DW-1:0] c_o;
   logic [EW-1:0] exp_o;
   logic [LW-1:0] lzc_o;
   logic          zero_o;
   logic          denorm_o;

   exp_t sb[$];
   int   n_vec;
   int   n_err;
   logic held;
   exp_t snap;
   logic rand_done;

   norm_shifter #(.DATA_WIDTH(DW), .EXP_WIDTH(EW)) dut (
      .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .ready_o(ready_o),
      .a_i(a_i), .exp_i(exp_i), .valid_o(valid_o), .ready_i(ready_i),
      .c_o(c_o), .exp_o(exp_o), .lzc_o(lzc_o), .zero_o(zero_o), .denorm_o(denorm_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: shift up until the MSB is set, but never by more than the exponent.
   function automatic exp_t model(input longint unsigned a, input longint unsigned e);
      exp_t r;
      longint unsigned lz;
      longint unsigned sh;
      lz = 0;
      if (a == 0) lz = DW;
      else while ((a * (64'd1 << lz)) < (64'd1 << (DW - 1))) lz++;
      sh = (lz < e) ? lz : e;
      r.c      = (a == 0) ? '0 : DW'(a * (64'd1 << sh));
      r.e      = (a == 0) ? '0 : EW'(e - sh);
      r.lzc    = LW'(lz);
      r.zero   = (a == 0);
      r.denorm = (lz > e) && (a != 0);
      return r;
   endfunction

   function automatic exp_t mk(input logic [DW-1:0] c, input int lz, input int e,
                               input logic z, input logic d);
      exp_t r;
      r.c = c; r.lzc = LW'(lz); r.e = EW'(e); r.zero = z; r.denorm = d;
      return r;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_vec++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
      end
   endtask

   task automatic monitor_loop();
      exp_t x;
      exp_t got;
      forever begin
         @(negedge clk);
         got = {c_o, exp_o, lzc_o, zero_o, denorm_o};
         if (rst_n && valid_o) begin
            if (held) chk("stall_stable", 32'(got != snap), 32'd0);
            if (!ready_i) begin
               chk("stall_ready_o", 32'(ready_o), 32'd0);
               held = 1'b1;
               snap = got;
            end else begin
               held = 1'b0;
               n_vec++;
               if (sb.size() == 0) begin
                  n_err++;
                  $display("FAIL unexpected_beat: c=%h exp=%0d with empty scoreboard", c_o, exp_o);
               end else begin
                  x = sb.pop_front();
                  if (got !== x) begin
                     n_err++;
                     $display("FAIL beat: got c=%h exp=%0d lzc=%0d z=%b d=%b, expected c=%h exp=%0d lzc=%0d z=%b d=%b",
                              c_o, exp_o, lzc_o, zero_o, denorm_o, x.c, x.e, x.lzc, x.zero, x.denorm);
                  end
               end
            end
         end else begin
            held = 1'b0;
         end
      end
   endtask

   // Entered just after a rising edge; returns just after the edge that took the beat.
   task automatic send(input logic [DW-1:0] a, input logic [EW-1:0] e, input exp_t x);
      int  w;
      logic done;
      valid_i = 1'b1; a_i = a; exp_i = e;
      w = 0; done = 1'b0;
      while (!done) begin
         @(negedge clk);
         if (ready_o) begin
            sb.push_back(x);
            done = 1'b1;
         end else begin
            w++;
            if (w > 200) begin
               chk("send_timeout", 32'd1, 32'd0);
               done = 1'b1;
            end
         end
      end
      @(posedge clk); #1;
      valid_i = 1'b0;
   endtask

   task automatic drain();
      int w;
      ready_i = 1'b1;
      w = 0;
      while ((sb.size() != 0 || valid_o) && w < 100) begin
         @(posedge clk); #1;
         w++;
      end
      chk("drain_pending", 32'(sb.size()), 32'd0);
   endtask

   task automatic rsend();
      logic [DW-1:0] a;
      logic [EW-1:0] e;
      a = DW'($urandom >> $urandom_range(0, 31));
      if ($urandom_range(0, 15) == 0) a = '0;
      e = EW'($urandom_range(0, 3) == 0 ? $urandom_range(0, 30) : $urandom_range(0, 255));
      send(a, e, model(longint'(a), longint'(e)));
   endtask

   initial begin
      n_vec = 0; n_err = 0; held = 1'b0; snap = '0; rand_done = 1'b0;
      rst_n = 1'b0; valid_i = 1'b0; ready_i = 1'b1; a_i = '0; exp_i = '0;
      fork monitor_loop(); join_none
      #3;
      chk("rst_valid_o", 32'(valid_o), 32'd0);
      chk("rst_c_o", 32'(c_o), 32'd0);
      chk("rst_exp_o", 32'(exp_o), 32'd0);
      chk("rst_flags", 32'({lzc_o, zero_o, denorm_o}), 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("idle_ready_o", 32'(ready_o), 32'd1);

      send(24'h000004, 8'd100, mk(24'h800000, 21, 79, 1'b0, 1'b0));
      send(24'hE00004, 8'd5,   mk(24'hE00004, 0, 5, 1'b0, 1'b0));
      send(24'h000100, 8'd10,  mk(24'h040000, 15, 0, 1'b0, 1'b1));
      send(24'h000000, 8'd50,  mk(24'h000000, 24, 0, 1'b1, 1'b0));
      send(24'h000001, 8'd0,   mk(24'h000001, 23, 0, 1'b0, 1'b1));
      send(24'h800000, 8'd0,   mk(24'h800000, 0, 0, 1'b0, 1'b0));
      send(24'h000002, 8'd22,  mk(24'h800000, 22, 0, 1'b0, 1'b0));
      drain();

      ready_i = 1'b0;
      fork
         begin
            send(24'h000001, 8'd100, mk(24'h800000, 23, 77, 1'b0, 1'b0));
            send(24'h000010, 8'd100, mk(24'h800000, 19, 81, 1'b0, 1'b0));
            send(24'h000100, 8'd100, mk(24'h800000, 15, 85, 1'b0, 1'b0));
            send(24'h001000, 8'd100, mk(24'h800000, 11, 89, 1'b0, 1'b0));
         end
         begin
            repeat (5) @(posedge clk);
            #1 ready_i = 1'b1;
         end
      join
      drain();

      send(24'h000300, 8'd40, model(64'h300, 64'd40));
      send(24'h00F000, 8'd40, model(64'hF000, 64'd40));
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_valid_o", 32'(valid_o), 32'd0);
      chk("midrst_c_o", 32'(c_o), 32'd0);
      chk("midrst_exp_lzc", 32'({exp_o, lzc_o, zero_o, denorm_o}), 32'd0);
      sb.delete();
      @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      send(24'h400000, 8'd3, mk(24'h800000, 1, 2, 1'b0, 1'b0));
      @(negedge clk);
      chk("lat_edge1_valid_o", 32'(valid_o), 32'd0);
      @(negedge clk);
      chk("lat_edge2_valid_o", 32'(valid_o), 32'd1);
      chk("lat_edge2_c_o", 32'(c_o), 32'h800000);
      chk("lat_edge2_exp_o", 32'(exp_o), 32'd2);
      @(posedge clk); #1;
      drain();

      fork
         begin
            for (int i = 0; i < 300; i++) begin
               rsend();
               if ($urandom_range(0, 4) == 0) begin
                  repeat ($urandom_range(1, 3)) begin
                     @(posedge clk); #1;
                  end
               end
            end
            rand_done = 1'b1;
         end
         begin
            while (!rand_done) begin
               @(posedge clk); #1;
               ready_i = ($urandom_range(0, 3) != 0);
            end
         end
      join
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
